// File: rtl/cnn_conv3x3_mac_if.sv
// Handshake and configuration bundle between the window reader, the 3x3 MAC and the
// result path.
interface cnn_conv3x3_mac_if;
  logic       strt;
  logic       din_vld;
  logic       din;
  logic       bsy;
  logic       wt_wr;
  logic [3:0] wt_addr;
  logic [7:0] wt_data;
  logic       out_vld;
  logic       out_rdy;
  logic [7:0] dout;
  logic [9:0] win_cnt;
  logic       frame_done;
  logic       frame_clr;

  modport slave (
    input  strt, din_vld, din, wt_wr, wt_addr, wt_data, out_rdy, frame_clr,
    output bsy, out_vld, dout, win_cnt, frame_done
  );

  modport master (
    output strt, din_vld, din, wt_wr, wt_addr, wt_data, out_rdy, frame_clr,
    input  bsy, out_vld, dout, win_cnt, frame_done
  );
endinterface

// File: rtl/cnn_conv3x3_mac.sv
// Serial 3x3 binary-window MAC: weighted tap sum plus bias, ReLU, scale and
// saturate to one activation byte, with a per-frame window counter.
module cnn_conv3x3_mac #(
  parameter int unsigned N_WIN = 676,
  parameter int unsigned SHIFT = 2,
  parameter int unsigned ACC_W = 13
) (
  input  logic              clk,
  input  logic              rst,
  cnn_conv3x3_mac_if.slave  bus
);

  typedef enum logic [1:0] {StIdle, StAcc, StSum, StOut} state_t;

  state_t                   state_q;
  logic signed [ACC_W-1:0]  acc_q;
  logic [3:0]               tap_q;
  logic                     bsy_q;
  logic                     out_vld_q;
  logic [7:0]               dout_q;
  logic [9:0]               win_cnt_q;
  logic                     frame_done_q;
  logic signed [7:0]        w_q [0:8];
  logic signed [7:0]        bias_q;

  logic signed [ACC_W-1:0]  sum;
  logic [ACC_W-1:0]         relu;
  logic [ACC_W-1:0]         shifted;
  logic [7:0]               sat;

  function automatic logic signed [ACC_W-1:0] sext(input logic signed [7:0] v);
    return {{(ACC_W-8){v[7]}}, v};
  endfunction

  always_comb begin
    sum     = acc_q + sext(bias_q);
    relu    = sum[ACC_W-1] ? '0 : sum;
    shifted = relu >> SHIFT;
    sat     = (shifted > ACC_W'(255)) ? 8'hFF : shifted[7:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      acc_q        <= '0;
      tap_q        <= '0;
      bsy_q        <= 1'b0;
      out_vld_q    <= 1'b0;
      dout_q       <= '0;
      win_cnt_q    <= '0;
      frame_done_q <= 1'b0;
      bias_q       <= '0;
      for (int i = 0; i < 9; i++) w_q[i] <= '0;
    end else begin
      frame_done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          // A write in the same cycle as strt lands after tap 0 was already sampled.
          if (bus.wt_wr) begin
            if (bus.wt_addr < 4'd9) w_q[bus.wt_addr] <= bus.wt_data;
            else if (bus.wt_addr == 4'd9) bias_q <= bus.wt_data;
          end
          if (bus.strt && bus.din_vld) begin
            acc_q   <= bus.din ? sext(w_q[0]) : '0;
            tap_q   <= 4'd1;
            bsy_q   <= 1'b1;
            state_q <= StAcc;
          end
        end
        StAcc: begin
          if (bus.din_vld) begin
            acc_q <= acc_q + (bus.din ? sext(w_q[tap_q]) : '0);
            tap_q <= tap_q + 4'd1;
            if (tap_q == 4'd8) state_q <= StSum;
          end
        end
        StSum: begin
          dout_q    <= sat;
          out_vld_q <= 1'b1;
          state_q   <= StOut;
        end
        StOut: begin
          if (bus.out_rdy) begin
            out_vld_q <= 1'b0;
            bsy_q     <= 1'b0;
            state_q   <= StIdle;
            if (win_cnt_q == 10'(N_WIN - 1)) begin
              win_cnt_q    <= '0;
              frame_done_q <= ~bus.frame_clr;
            end else begin
              win_cnt_q <= win_cnt_q + 10'd1;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
      // Clear wins over a coincident handshake and suppresses its pulse.
      if (bus.frame_clr) begin
        win_cnt_q    <= '0;
        frame_done_q <= 1'b0;
      end
    end
  end

  assign bus.bsy        = bsy_q;
  assign bus.out_vld    = out_vld_q;
  assign bus.dout       = dout_q;
  assign bus.win_cnt    = win_cnt_q;
  assign bus.frame_done = frame_done_q;

endmodule

// File: tb/tb_cnn_conv3x3_mac.sv
// Randomised self-checking bench for cnn_conv3x3_mac against an arithmetic reference model.
module tb_cnn_conv3x3_mac;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;
  int   model_w [9];
  int   model_b;

  cnn_conv3x3_mac_if ifc();

  cnn_conv3x3_mac dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int model_dout(input logic [8:0] bits);
    int r = model_b;
    for (int i = 0; i < 9; i++) if (bits[i]) r += model_w[i];
    if (r < 0) r = 0;
    r = r / 4;
    if (r > 255) r = 255;
    return r;
  endfunction

  task automatic write_wt(input int addr, input int val);
    ifc.wt_wr   = 1'b1;
    ifc.wt_addr = 4'(addr);
    ifc.wt_data = 8'(val);
    tick();
    ifc.wt_wr = 1'b0;
    if (addr < 9) model_w[addr] = val;
    else if (addr == 9) model_b = val;
  endtask

  task automatic set_all(input int w, input int b);
    for (int i = 0; i < 9; i++) write_wt(i, w);
    write_wt(9, b);
  endtask

  // Streams one window; optionally pulses wt_wr alongside beat wr_beat.
  task automatic send_window(input logic [8:0] bits, input int gap, input int wr_beat,
                             input int wr_addr, input int wr_data,
                             output int lat, output bit bsy_ok);
    bsy_ok = 1'b1;
    for (int i = 0; i < 9; i++) begin
      ifc.strt    = (i == 0);
      ifc.din_vld = 1'b1;
      ifc.din     = bits[i];
      if (i == wr_beat) begin
        ifc.wt_wr   = 1'b1;
        ifc.wt_addr = 4'(wr_addr);
        ifc.wt_data = 8'(wr_data);
      end
      tick();
      ifc.wt_wr   = 1'b0;
      ifc.strt    = 1'b0;
      ifc.din_vld = 1'b0;
      ifc.din     = 1'b0;
      if (ifc.bsy !== 1'b1) bsy_ok = 1'b0;
      if (i < 8) repeat (gap) begin
        tick();
        if (ifc.bsy !== 1'b1) bsy_ok = 1'b0;
      end
    end
    lat = 1;
    while (ifc.out_vld !== 1'b1 && lat < 30) begin
      tick();
      lat++;
    end
  endtask

  // Holds out_rdy low for stall cycles, then completes the handshake.
  task automatic finish_out(input int stall, input bit poke_strt, output bit stable);
    logic [7:0] d;
    d = ifc.dout;
    stable = 1'b1;
    ifc.strt    = poke_strt;
    ifc.din_vld = poke_strt;
    ifc.din     = poke_strt;
    repeat (stall) begin
      tick();
      if (ifc.out_vld !== 1'b1 || ifc.dout !== d || ifc.bsy !== 1'b1) stable = 1'b0;
    end
    ifc.out_rdy = 1'b1;
    tick();
    ifc.out_rdy = 1'b0;
    ifc.strt    = 1'b0;
    ifc.din_vld = 1'b0;
    ifc.din     = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    n_cmp += 5;
    if (ifc.bsy !== 1'b0) begin n_err++; $display("FAIL reset_bsy got %b want 0", ifc.bsy); end
    if (ifc.out_vld !== 1'b0) begin
      n_err++; $display("FAIL reset_out_vld got %b want 0", ifc.out_vld);
    end
    if (ifc.dout !== 8'h00) begin n_err++; $display("FAIL reset_dout got %h want 00", ifc.dout); end
    if (ifc.win_cnt !== 10'd0) begin
      n_err++; $display("FAIL reset_win_cnt got %0d want 0", ifc.win_cnt);
    end
    if (ifc.frame_done !== 1'b0) begin
      n_err++; $display("FAIL reset_frame_done got %b want 0", ifc.frame_done);
    end
    rst = 1'b0;
    tick();
    for (int i = 0; i < 9; i++) model_w[i] = 0;
    model_b = 0;
  endtask

  // Runs a full window and checks latency, result and the handshake release.
  task automatic run_checked(input string name, input logic [8:0] bits, input int gap,
                             input int stall, input int expect_d);
    int lat;
    bit bsy_ok, stable;
    send_window(bits, gap, -1, 0, 0, lat, bsy_ok);
    n_cmp += 4;
    if (lat != 2) begin n_err++; $display("FAIL %s_latency got %0d want 2", name, lat); end
    if (ifc.dout !== 8'(expect_d)) begin
      n_err++; $display("FAIL %s_dout got %0d want %0d", name, ifc.dout, expect_d);
    end
    if (int'(ifc.dout) != model_dout(bits)) begin
      n_err++; $display("FAIL %s_model got %0d want %0d", name, ifc.dout, model_dout(bits));
    end
    if (!bsy_ok) begin n_err++; $display("FAIL %s_bsy got 0 want 1 during window", name); end
    finish_out(stall, 1'b0, stable);
    n_cmp += 2;
    if (!stable) begin n_err++; $display("FAIL %s_stall_stable got 0 want 1", name); end
    if (ifc.out_vld !== 1'b0 || ifc.bsy !== 1'b0) begin
      n_err++; $display("FAIL %s_release got vld=%b bsy=%b want 0 0", name, ifc.out_vld, ifc.bsy);
    end
  endtask

  task automatic test_basic();
    set_all(1, 0);
    run_checked("basic", 9'h1FF, 0, 0, 2);
  endtask

  task automatic test_saturate();
    set_all(127, 127);
    run_checked("saturate", 9'h1FF, 0, 1, 255);
  endtask

  task automatic test_relu();
    set_all(-5, 10);
    run_checked("relu", 9'b000000111, 0, 0, 0);
  endtask

  task automatic test_random();
    logic [8:0] bits;
    for (int k = 0; k < 6; k++) begin
      for (int i = 0; i < 9; i++) write_wt(i, int'($urandom_range(0, 255)) - 128);
      write_wt(9, int'($urandom_range(0, 255)) - 128);
      write_wt(int'($urandom_range(10, 15)), int'($urandom_range(0, 255)) - 128);
      bits = 9'($urandom);
      run_checked("random", bits, int'($urandom_range(0, 3)), int'($urandom_range(0, 4)),
                  model_dout(bits));
    end
  endtask

  task automatic test_stall();
    int lat;
    bit bsy_ok, stable;
    set_all(1, 0);
    send_window(9'h1FF, 3, -1, 0, 0, lat, bsy_ok);
    n_cmp += 3;
    if (lat != 2) begin n_err++; $display("FAIL stall_latency got %0d want 2", lat); end
    if (ifc.dout !== 8'h02) begin n_err++; $display("FAIL stall_dout got %h want 02", ifc.dout); end
    if (!bsy_ok) begin n_err++; $display("FAIL stall_bsy got 0 want 1 during gaps"); end
    finish_out(5, 1'b1, stable);
    n_cmp += 2;
    if (!stable) begin n_err++; $display("FAIL stall_hold got unstable want stable"); end
    if (ifc.bsy !== 1'b0 || ifc.out_vld !== 1'b0) begin
      n_err++; $display("FAIL stall_strt_ignored got bsy=%b vld=%b want 0 0", ifc.bsy, ifc.out_vld);
    end
  endtask

  task automatic test_weight_freeze();
    int lat;
    bit bsy_ok, stable;
    set_all(2, 0);
    send_window(9'h1FF, 0, 3, 4, 100, lat, bsy_ok);
    n_cmp += 1;
    if (ifc.dout !== 8'(model_dout(9'h1FF))) begin
      n_err++; $display("FAIL freeze_dout got %0d want %0d", ifc.dout, model_dout(9'h1FF));
    end
    finish_out(0, 1'b0, stable);
    run_checked("freeze_after", 9'b000010000, 0, 0, 0);
  endtask

  task automatic test_rst_mid();
    int lat;
    bit bsy_ok;
    set_all(3, 4);
    for (int i = 0; i < 5; i++) begin
      ifc.strt = (i == 0); ifc.din_vld = 1'b1; ifc.din = 1'b1;
      tick();
    end
    ifc.strt = 1'b0; ifc.din_vld = 1'b0; ifc.din = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 9; i++) model_w[i] = 0;
    model_b = 0;
    n_cmp += 2;
    if (ifc.bsy !== 1'b0) begin n_err++; $display("FAIL rstmid_bsy got %b want 0", ifc.bsy); end
    if (ifc.out_vld !== 1'b0) begin
      n_err++; $display("FAIL rstmid_out_vld got %b want 0", ifc.out_vld);
    end
    run_checked("rstmid_new", 9'h1FF, 0, 0, 0);
    lat = 0; bsy_ok = 1'b0;
  endtask

  task automatic test_back_to_back();
    int lat, cnt, pulses, clr_idx;
    bit bsy_ok, clr;
    ifc.frame_clr = 1'b1;
    tick();
    ifc.frame_clr = 1'b0;
    n_cmp += 1;
    if (ifc.win_cnt !== 10'd0 || ifc.frame_done !== 1'b0) begin
      n_err++; $display("FAIL clr_idle got cnt=%0d fd=%b want 0 0", ifc.win_cnt, ifc.frame_done);
    end
    cnt = 0;
    pulses = 0;
    clr_idx = 299;
    ifc.out_rdy = 1'b1;
    for (int w = 0; w < 300 + 676; w++) begin
      send_window(9'($urandom), 0, -1, 0, 0, lat, bsy_ok);
      if (lat >= 30) begin
        n_cmp++; n_err++;
        $display("FAIL stream_timeout got no out_vld want out_vld at window %0d", w);
        break;
      end
      clr = (w == clr_idx);
      ifc.frame_clr = clr;
      tick();
      ifc.frame_clr = 1'b0;
      if (ifc.frame_done === 1'b1) pulses++;
      n_cmp += 2;
      if (!clr && cnt == 675) begin
        cnt = 0;
        if (ifc.frame_done !== 1'b1) begin
          n_err++; $display("FAIL frame_done_at_%0d got 0 want 1", w);
        end
      end else begin
        cnt = clr ? 0 : cnt + 1;
        if (ifc.frame_done !== 1'b0) begin
          n_err++; $display("FAIL frame_done_spurious_%0d got 1 want 0", w);
        end
      end
      if (ifc.win_cnt !== 10'(cnt)) begin
        n_err++; $display("FAIL win_cnt_%0d got %0d want %0d", w, ifc.win_cnt, cnt);
      end
    end
    ifc.out_rdy = 1'b0;
    tick();
    n_cmp += 2;
    if (pulses != 1) begin n_err++; $display("FAIL frame_pulses got %0d want 1", pulses); end
    if (ifc.frame_done !== 1'b0) begin
      n_err++; $display("FAIL frame_done_one_cycle got 1 want 0");
    end
  endtask

  initial begin
    ifc.strt = 1'b0; ifc.din_vld = 1'b0; ifc.din = 1'b0;
    ifc.wt_wr = 1'b0; ifc.wt_addr = '0; ifc.wt_data = '0;
    ifc.out_rdy = 1'b0; ifc.frame_clr = 1'b0;
    test_reset();
    test_basic();
    test_saturate();
    test_relu();
    test_random();
    test_stall();
    test_weight_freeze();
    test_rst_mid();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
